// File: rtl/scarv_cop_pkg.sv
// Shared coprocessor types and sizes for the MALU writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scarv_cop_pkg;

  localparam int CPR_NREGS = 16;
  localparam int CPR_AW    = 4;
  localparam int CPR_DW    = 32;

  // The high half of a wide result is always written as a full word.
  localparam logic [3:0] CPR_BEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } malu_wb_state_t;

endpackage

// File: rtl/scarv_cop_wb_scoreboard.sv
// Pending-write busy vector: one bit per CPR, set on accept, cleared on write.
// Latency: set/clear take effect on the next clock edge.
// Backpressure: none; set wins over clear so back-to-back writes stay busy.
module scarv_cop_wb_scoreboard #(
  parameter int NREGS = 16
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic [NREGS-1:0] set_vec,
  input  logic [NREGS-1:0] clr_vec,
  output logic [NREGS-1:0] busy
);

  // Clear first, then OR in the new sets so a same-cycle set keeps the bit high.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/scarv_cop_malu_wb.sv
// MALU writeback sequencer: turns a narrow/wide result into byte-enabled CPR writes.
// Latency: lo write one cycle after accept, hi write two cycles after (wide only).
// Backpressure: wb_ready drops only during the lo write of a wide result.
// Option: SCARV_COP_MALU_WB_BYPASS_EN lets a narrow result accepted in IDLE write the same cycle.
module scarv_cop_malu_wb
  import scarv_cop_pkg::*;
#(
  parameter int NREGS = CPR_NREGS,
  parameter int AW    = CPR_AW,
  parameter int DW    = CPR_DW
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             wb_ivalid,
  output logic             wb_ready,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_wide,
  input  logic [3:0]       wb_ben,
  input  logic [DW-1:0]    wb_wdata,
  input  logic [DW-1:0]    wb_wdata_hi,
  output logic             cpr_rd_wen,
  output logic [AW-1:0]    cpr_rd_addr,
  output logic [3:0]       cpr_rd_ben,
  output logic [DW-1:0]    cpr_rd_wdata,
  output logic             wb_done,
  output logic [NREGS-1:0] wb_busy
);

  localparam logic [AW-1:0]    RD_BIT0 = AW'(1);
  localparam logic [NREGS-1:0] ONE_HOT = NREGS'(1);

  malu_wb_state_t state_q, state_d;

  // Holding registers for the second half of a wide result.
  logic            wide_q;
  logic [AW-1:0]   rd_hi_q;
  logic [DW-1:0]   hi_q;

  // Registered write port; these are the values driven during WR_LO/WR_HI.
  logic            wen_q,  wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      ben_q,  ben_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;

  logic            accept;
  logic            byp_hit;
  logic            accept_reg;
  logic [AW-1:0]   rd_lo;
  logic [AW-1:0]   rd_hi;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // Even/odd pair addressing; for narrow results rd is used unmodified.
  assign rd_lo = wb_wide ? (wb_rd & ~RD_BIT0) : wb_rd;
  assign rd_hi = wb_rd | RD_BIT0;

  assign wb_ready = (state_q == IDLE) | ((state_q == WR_LO) & !wide_q) | (state_q == WR_HI);
  assign accept   = wb_ivalid & wb_ready;

`ifdef SCARV_COP_MALU_WB_BYPASS_EN
  assign byp_hit = accept & (state_q == IDLE) & !wb_wide;
`else
  assign byp_hit = 1'b0;
`endif

  // Results that go through the holding registers rather than the bypass.
  assign accept_reg = accept & !byp_hit;

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the write that the next state will drive.
  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    ben_d   = ben_q;
    data_d  = data_q;

    case (state_q)
      IDLE:    state_d = accept_reg ? WR_LO : IDLE;
      WR_LO:   state_d = wide_q ? WR_HI : (accept_reg ? WR_LO : IDLE);
      WR_HI:   state_d = accept_reg ? WR_LO : IDLE;
      default: state_d = IDLE;
    endcase

    // Entering WR_LO only happens on an accept, so the live inputs are the source.
    if (state_d == WR_LO) begin
      wen_d  = |wb_ben;
      addr_d = rd_lo;
      ben_d  = wb_ben;
      data_d = wb_wdata;
      done_d = !wb_wide;
    end else if (state_d == WR_HI) begin
      wen_d  = 1'b1;
      addr_d = rd_hi_q;
      ben_d  = CPR_BEN_ALL;
      data_d = hi_q;
      done_d = 1'b1;
    end
  end

  // Capture the wide-result high half and pair index on every registered accept.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wide_q  <= 1'b0;
      rd_hi_q <= '0;
      hi_q    <= '0;
    end else if (accept_reg) begin
      wide_q  <= wb_wide;
      rd_hi_q <= rd_hi;
      hi_q    <= wb_wdata_hi;
    end
  end

  // Write-port output registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      ben_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      addr_q <= addr_d;
      ben_q  <= ben_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end

`ifdef SCARV_COP_MALU_WB_BYPASS_EN
  // In IDLE the registered port is quiet, so the bypass can take it over.
  assign cpr_rd_wen   = byp_hit ? |wb_ben  : wen_q;
  assign cpr_rd_addr  = byp_hit ? wb_rd    : addr_q;
  assign cpr_rd_ben   = byp_hit ? wb_ben   : ben_q;
  assign cpr_rd_wdata = byp_hit ? wb_wdata : data_q;
  assign wb_done      = byp_hit | done_q;
`else
  assign cpr_rd_wen   = wen_q;
  assign cpr_rd_addr  = addr_q;
  assign cpr_rd_ben   = ben_q;
  assign cpr_rd_wdata = data_q;
  assign wb_done      = done_q;
`endif

  // Busy bits: set for every register a registered accept will write,
  // cleared for the register whose write slot is the current cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept_reg) begin
      set_vec = ONE_HOT << rd_lo;
      if (wb_wide) begin
        set_vec = set_vec | (ONE_HOT << rd_hi);
      end
    end
    if ((state_q == WR_LO) || (state_q == WR_HI)) begin
      clr_vec = ONE_HOT << addr_q;
    end
  end

  scarv_cop_wb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .set_vec  (set_vec),
    .clr_vec  (clr_vec),
    .busy     (wb_busy)
  );

endmodule

// File: tb/tb_scarv_cop_malu_wb.sv
// Bench for the MALU writeback sequencer: directed results, queued expectations.
// Latency: expected writes carry the cycle they must appear in.
// Backpressure: stimulus waits (bounded) on wb_ready before each result.
module tb_scarv_cop_malu_wb;
  import scarv_cop_pkg::*;

`ifdef SCARV_COP_MALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        g_clk;
  logic        g_resetn;
  logic        wb_ivalid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic        wb_wide;
  logic [3:0]  wb_ben;
  logic [31:0] wb_wdata;
  logic [31:0] wb_wdata_hi;
  logic        cpr_rd_wen;
  logic [3:0]  cpr_rd_addr;
  logic [3:0]  cpr_rd_ben;
  logic [31:0] cpr_rd_wdata;
  logic        wb_done;
  logic [15:0] wb_busy;

  scarv_cop_malu_wb dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .wb_ivalid    (wb_ivalid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_wide      (wb_wide),
    .wb_ben       (wb_ben),
    .wb_wdata     (wb_wdata),
    .wb_wdata_hi  (wb_wdata_hi),
    .cpr_rd_wen   (cpr_rd_wen),
    .cpr_rd_addr  (cpr_rd_addr),
    .cpr_rd_ben   (cpr_rd_ben),
    .cpr_rd_wdata (cpr_rd_wdata),
    .wb_done      (wb_done),
    .wb_busy      (wb_busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          wen;
    logic [3:0]  addr;
    logic [3:0]  ben;
    logic [31:0] data;
    bit          done;
  } ev_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } pr_t;

  ev_t evq[$];
  pr_t prq[$];
  int  checks  = 0;
  int  errors  = 0;
  bit  stim_done = 1'b0;
  bit  stim_to   = 1'b0;
  int  last_wr   = -1;

  function automatic void probe(input int c, input int k, input logic [31:0] v);
    pr_t p;
    p.cyc = c; p.kind = k; p.val = v;
    prq.push_back(p);
  endfunction

  function automatic logic [31:0] val_of(input int k);
    case (k)
      0:       return 32'(wb_busy);
      1:       return 32'(wb_ready);
      2:       return 32'(cpr_rd_wen);
      3:       return 32'(wb_done);
      4:       return 32'(cpr_rd_addr);
      5:       return 32'(cpr_rd_ben);
      default: return cpr_rd_wdata;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "wb_busy";
      1:       return "wb_ready";
      2:       return "cpr_rd_wen";
      3:       return "wb_done";
      4:       return "cpr_rd_addr";
      5:       return "cpr_rd_ben";
      default: return "cpr_rd_wdata";
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  // Present one result, wait for ready, and queue the writes it must produce.
  task automatic send(input logic [3:0] rd, input bit wide, input logic [3:0] ben,
                      input logic [31:0] lo, input logic [31:0] hi);
    int  n;
    int  c;
    int  cw;
    bit  byp;
    ev_t e;
    n = 0;
    wb_ivalid   = 1'b1;
    wb_rd       = rd;
    wb_wide     = wide;
    wb_ben      = ben;
    wb_wdata    = lo;
    wb_wdata_hi = hi;
    while (!wb_ready && n < 20) begin
      @(posedge g_clk);
      #1;
      n++;
    end
    if (n >= 20) stim_to = 1'b1;
    c   = cyc;
    byp = BYP && !wide && (c > last_wr);
    if (wide) begin
      e = '{c + 1, |ben, rd & 4'hE, ben, lo, 1'b0};
      evq.push_back(e);
      e = '{c + 2, 1'b1, rd | 4'h1, 4'hF, hi, 1'b1};
      evq.push_back(e);
      last_wr = c + 2;
    end else begin
      cw = byp ? c : c + 1;
      e  = '{cw, |ben, rd, ben, lo, 1'b1};
      evq.push_back(e);
      last_wr = cw;
    end
    @(posedge g_clk);
    #1;
    wb_ivalid = 1'b0;
  endtask

  // Stimulus
  initial begin : stim
    int c;
    g_resetn    = 1'b0;
    wb_ivalid   = 1'b0;
    wb_rd       = '0;
    wb_wide     = 1'b0;
    wb_ben      = '0;
    wb_wdata    = '0;
    wb_wdata_hi = '0;
    idle(3);
    g_resetn = 1'b1;

    // Reset state
    c = cyc;
    probe(c, 0, 32'h0);
    probe(c, 1, 32'h1);
    probe(c, 2, 32'h0);
    probe(c, 3, 32'h0);
    probe(c, 4, 32'h0);
    probe(c, 6, 32'h0);
    idle(1);

    // Narrow rd=5: busy[5] high exactly one cycle
    c = cyc;
    probe(c, 1, 32'h1);
    probe(c + 1, 0, BYP ? 32'h0 : 32'h20);
    probe(c + 2, 0, 32'h0);
    send(4'd5, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0);
    idle(3);

    // Wide rd=7: lo to c6, hi to c7, ready low during lo write
    c = cyc;
    probe(c + 1, 1, 32'h0);
    probe(c + 1, 0, 32'hC0);
    probe(c + 2, 0, 32'h80);
    probe(c + 3, 0, 32'h0);
    send(4'd7, 1'b1, 4'hF, 32'h11111111, 32'h22222222);
    idle(3);

    // Back-to-back narrow to rd=3: busy[3] held across both writes
    c = cyc;
    probe(c + 1, 0, BYP ? 32'h0 : 32'h8);
    probe(c + 2, 0, BYP ? 32'h0 : 32'h8);
    probe(c + 3, 0, 32'h0);
    send(4'd3, 1'b0, 4'hF, 32'hA1A1A1A1, 32'h0);
    send(4'd3, 1'b0, 4'hF, 32'hB2B2B2B2, 32'h0);
    idle(3);

    // Narrow with no byte enables: done pulses, no write strobe
    c = cyc;
    probe(c + 1, 0, BYP ? 32'h0 : 32'h10);
    probe(c + 2, 0, 32'h0);
    send(4'd4, 1'b0, 4'h0, 32'h12345678, 32'h0);
    idle(3);

    // Wide rd=10 (partial lo enables) immediately followed by narrow rd=1
    c = cyc;
    probe(c + 1, 1, 32'h0);
    probe(c + 1, 0, 32'hC00);
    probe(c + 2, 1, 32'h1);
    probe(c + 2, 0, 32'h800);
    probe(c + 3, 0, 32'h2);
    probe(c + 4, 0, 32'h0);
    send(4'd10, 1'b1, 4'h3, 32'h33333333, 32'h44444444);
    send(4'd1, 1'b0, 4'hF, 32'h55555555, 32'h0);
    idle(3);

    // Reset during the lo write of a wide rd=2: the c3 write must never appear
    c = cyc;
    probe(c + 1, 0, 32'hC);
    probe(c + 2, 0, 32'h0);
    probe(c + 2, 1, 32'h1);
    probe(c + 2, 2, 32'h0);
    probe(c + 3, 0, 32'h0);
    probe(c + 3, 1, 32'h1);
    probe(c + 3, 3, 32'h0);
    send(4'd2, 1'b1, 4'hF, 32'h66666666, 32'h77777777);
    #5;
    g_resetn = 1'b0;
    void'(evq.pop_back());
    last_wr = c + 1;
    @(posedge g_clk);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    idle(4);

    // Narrow rd=9 from IDLE (same-cycle write when the bypass is built in)
    c = cyc;
    probe(c, 0, 32'h0);
    probe(c + 1, 0, BYP ? 32'h0 : 32'h200);
    probe(c + 2, 0, 32'h0);
    send(4'd9, 1'b0, 4'hF, 32'h99999999, 32'h0);
    idle(3);

    stim_done = 1'b1;
  end

  // Monitor: every write/done the DUT presents is matched against the queue,
  // and queued probes are compared in the cycle they name.
  initial begin : mon
    ev_t e;
    bit  ok;
    while (!stim_done && cyc < 3000) begin
      @(negedge g_clk);
      if (g_resetn && (cpr_rd_wen || wb_done)) begin
        checks++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL wr_event @%0d: got wen=%0b done=%0b addr=%0d data=%h, expected no write",
                   cyc, cpr_rd_wen, wb_done, cpr_rd_addr, cpr_rd_wdata);
        end else begin
          e  = evq.pop_front();
          ok = (cyc == e.cyc) && (cpr_rd_wen == e.wen) && (wb_done == e.done) &&
               (!e.wen || (cpr_rd_addr == e.addr && cpr_rd_ben == e.ben && cpr_rd_wdata == e.data));
          if (!ok) begin
            errors++;
            $display("FAIL wr_event: got cyc=%0d wen=%0b addr=%0d ben=%h data=%h done=%0b, expected cyc=%0d wen=%0b addr=%0d ben=%h data=%h done=%0b",
                     cyc, cpr_rd_wen, cpr_rd_addr, cpr_rd_ben, cpr_rd_wdata, wb_done,
                     e.cyc, e.wen, e.addr, e.ben, e.data, e.done);
          end
        end
      end
      for (int i = prq.size() - 1; i >= 0; i--) begin
        if (prq[i].cyc <= cyc) begin
          checks++;
          if (val_of(prq[i].kind) !== prq[i].val) begin
            errors++;
            $display("FAIL probe %s @%0d: got %h, expected %h",
                     kname(prq[i].kind), cyc, val_of(prq[i].kind), prq[i].val);
          end
          prq.delete(i);
        end
      end
    end
    checks++;
    if (!stim_done) begin
      errors++;
      $display("FAIL timeout: stimulus incomplete at cycle %0d, expected completion", cyc);
    end
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d writes never seen, expected 0", evq.size());
    end
    checks++;
    if (stim_to) begin
      errors++;
      $display("FAIL ready_wait: wb_ready stayed low, expected it to rise within 20 cycles");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
